// File: rtl/ntt_butterfly.sv
// ntt_butterfly: 4-stage pipelined radix-2 NTT butterfly mod q = 8380417 (Dilithium).
// Define NTT_BUTTERFLY_GS_EN to add in_mode and the Gentleman-Sande inverse butterfly.
module ntt_butterfly #(
  parameter int                DATA_W = 23,
  parameter logic [DATA_W-1:0] Q      = 23'h7FE001,
  parameter int                TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_w,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef NTT_BUTTERFLY_GS_EN
  input  logic              in_mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int K   = 13;            // 2^23 == 2^13 - 1 (mod Q)
  localparam int PW  = 2 * DATA_W;    // raw product
  localparam int F1W = DATA_W + K;    // after first fold, < 2^36
  localparam int F2W = 2 * K + 1;     // after second fold, < 2^27
  localparam int F3W = DATA_W + 1;    // after third fold, < 2Q
  localparam int H3W = F2W - DATA_W;

  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [F3W-1:0] s;
    s = F3W'(x) + F3W'(y);
    return (s >= F3W'(Q)) ? DATA_W'(s - F3W'(Q)) : s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [F3W-1:0] d;
    d = F3W'(x) - F3W'(y);
    return d[DATA_W] ? DATA_W'(d + F3W'(Q)) : d[DATA_W-1:0];
  endfunction

  logic en;
  logic v1_q, v2_q, v3_q, v4_q;

  logic [PW-1:0]     p1_d, p1_q;
  logic [DATA_W-1:0] a1_d, a1_q, a2_q, a3_q, mul_b;
  logic [TAG_W-1:0]  tag1_q, tag2_q, tag3_q, out_tag_q;
  logic [F1W-1:0]    f2_d, f2_q;
  logic [DATA_W-1:0] t3_d, t3_q;
  logic [DATA_W-1:0] out_a_d, out_a_q, out_b_d, out_b_q;
  logic [F2W-1:0]    g2;
  logic [F3W-1:0]    h3;
`ifdef NTT_BUTTERFLY_GS_EN
  logic m1_q, m2_q, m3_q;
`endif

  // The whole pipeline advances or freezes together.
  assign en        = !v4_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v4_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_tag   = out_tag_q;

  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    mul_b = in_b;
    a1_d  = in_a;
`ifdef NTT_BUTTERFLY_GS_EN
    if (in_mode) begin
      mul_b = sub_mod(in_a, in_b);
      a1_d  = add_mod(in_a, in_b);
    end
`endif
    p1_d = PW'(mul_b) * PW'(in_w);
  end

  // Three folds of x = hi*2^23 + lo into hi*(2^13-1) + lo, then one conditional subtract.
  always_comb begin
    f2_d = {p1_q[PW-1:DATA_W], {K{1'b0}}} - F1W'(p1_q[PW-1:DATA_W]) + F1W'(p1_q[DATA_W-1:0]);
    g2   = F2W'({f2_q[F1W-1:DATA_W], {K{1'b0}}}) - F2W'(f2_q[F1W-1:DATA_W])
         + F2W'(f2_q[DATA_W-1:0]);
    h3   = F3W'({g2[F2W-1:DATA_W], {K{1'b0}}}) - F3W'(H3W'(g2[F2W-1:DATA_W]))
         + F3W'(g2[DATA_W-1:0]);
    t3_d = (h3 >= F3W'(Q)) ? DATA_W'(h3 - F3W'(Q)) : h3[DATA_W-1:0];
  end

  always_comb begin
    out_a_d = add_mod(a3_q, t3_q);
    out_b_d = sub_mod(a3_q, t3_q);
`ifdef NTT_BUTTERFLY_GS_EN
    if (m3_q) begin
      out_a_d = a3_q;
      out_b_d = t3_q;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      v4_q      <= 1'b0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_tag_q <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
      if (v3_q) begin
        out_a_q   <= out_a_d;
        out_b_q   <= out_b_d;
        out_tag_q <= tag3_q;
      end
    end
  end

  // NOTE: inner data registers are deliberately left unreset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      p1_q   <= p1_d;
      a1_q   <= a1_d;
      tag1_q <= in_tag;
`ifdef NTT_BUTTERFLY_GS_EN
      m1_q   <= in_mode;
`endif
    end
    if (en && v1_q) begin
      f2_q   <= f2_d;
      a2_q   <= a1_q;
      tag2_q <= tag1_q;
`ifdef NTT_BUTTERFLY_GS_EN
      m2_q   <= m1_q;
`endif
    end
    if (en && v2_q) begin
      t3_q   <= t3_d;
      a3_q   <= a2_q;
      tag3_q <= tag2_q;
`ifdef NTT_BUTTERFLY_GS_EN
      m3_q   <= m2_q;
`endif
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed vector table, stalled stream, reset flush,
// and (with NTT_BUTTERFLY_GS_EN) mixed CT/GS beats.
module tb_ntt_butterfly;

  localparam logic [22:0] Q = 23'h7FE001;

  typedef struct {
    logic [22:0] a, b, w;
    logic [7:0]  tag;
    logic        mode;
    logic [22:0] exp_a, exp_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [22:0] in_a, in_b, in_w, out_a, out_b;
  logic [7:0]  in_tag, out_tag;
`ifdef NTT_BUTTERFLY_GS_EN
  logic        in_mode;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  vec_t sv[16];
  int   sn;

  ntt_butterfly dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .in_tag    (in_tag),
`ifdef NTT_BUTTERFLY_GS_EN
    .in_mode   (in_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Golden model: plain wide-integer modular arithmetic.
  function automatic vec_t model(input logic [22:0] a, input logic [22:0] b, input logic [22:0] w,
                                 input logic [7:0] tag, input logic mode);
    longint unsigned q, t, ea, eb, d;
    vec_t r;
    q = 64'd8380417;
    if (!mode) begin
      t  = (longint'(b) * longint'(w)) % q;
      ea = (longint'(a) + t) % q;
      eb = (longint'(a) + q - t) % q;
    end else begin
      ea = (longint'(a) + longint'(b)) % q;
      d  = (longint'(a) + q - longint'(b)) % q;
      eb = (d * longint'(w)) % q;
    end
    r.a = a; r.b = b; r.w = w; r.tag = tag; r.mode = mode;
    r.exp_a = 23'(ea);
    r.exp_b = 23'(eb);
    return r;
  endfunction

  function automatic vec_t mk(input logic [22:0] a, input logic [22:0] b, input logic [22:0] w,
                              input logic [7:0] tag, input logic mode,
                              input logic [22:0] ea, input logic [22:0] eb);
    vec_t r;
    r.a = a; r.b = b; r.w = w; r.tag = tag; r.mode = mode; r.exp_a = ea; r.exp_b = eb;
    return r;
  endfunction

  task automatic drive_beat(input vec_t v);
    in_a     = v.a;
    in_b     = v.b;
    in_w     = v.w;
    in_tag   = v.tag;
`ifdef NTT_BUTTERFLY_GS_EN
    in_mode  = v.mode;
`endif
    in_valid = 1'b1;
  endtask

  // One isolated beat: checks acceptance, 4-cycle latency and the result.
  task automatic send_one(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    drive_beat(v);
    #1;
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'd4);
    check({name, ".out_a"}, 32'(out_a), 32'(v.exp_a));
    check({name, ".out_b"}, 32'(out_b), 32'(v.exp_b));
    check({name, ".out_tag"}, 32'(out_tag), 32'(v.tag));
  endtask

  // Streams sv[0..sn-1] back to back; out_ready is low for cycles stall_lo..stall_hi.
  task automatic run_stream(input int stall_lo, input int stall_hi, input string name);
    int          idx, got, c, extra;
    logic        stalled_prev;
    logic [22:0] pa, pb;
    logic [7:0]  pt;
    idx = 0; got = 0; c = 0; stalled_prev = 1'b0;
    pa = '0; pb = '0; pt = '0;
    while (got < sn && c < 200) begin
      @(negedge clk);
      out_ready = !(c >= stall_lo && c <= stall_hi);
      if (idx < sn) drive_beat(sv[idx]);
      else in_valid = 1'b0;
      #1;
      if (stalled_prev) begin
        check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
        check({name, ".hold_a"}, 32'(out_a), 32'(pa));
        check({name, ".hold_b"}, 32'(out_b), 32'(pb));
        check({name, ".hold_tag"}, 32'(out_tag), 32'(pt));
      end
      if (out_valid && !out_ready) check({name, ".stall_in_ready"}, 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        check($sformatf("%s[%0d].out_a", name, got), 32'(out_a), 32'(sv[got].exp_a));
        check($sformatf("%s[%0d].out_b", name, got), 32'(out_b), 32'(sv[got].exp_b));
        check($sformatf("%s[%0d].out_tag", name, got), 32'(out_tag), 32'(sv[got].tag));
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      pa = out_a; pb = out_b; pt = out_tag;
      if (in_valid && in_ready) idx++;
      c++;
    end
    check({name, ".beats_out"}, 32'(got), 32'(sn));
    check({name, ".beats_in"}, 32'(idx), 32'(sn));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check({name, ".no_duplicates"}, 32'(extra), 32'd0);
  endtask

  vec_t tbl[12];
  int   n_tbl;

  initial begin
    int seen;
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_w = '0; in_tag = '0;
`ifdef NTT_BUTTERFLY_GS_EN
    in_mode = 1'b0;
`endif

    // Hand-computed directed vectors.
    tbl[0] = mk(23'd5, 23'd3, 23'd1, 8'h11, 1'b0, 23'd8, 23'd2);
    tbl[1] = mk(23'd0, 23'd1, 23'h495e02, 8'h22, 1'b0, 23'd4808194, 23'd3572223);
    tbl[2] = mk(Q - 23'd1, Q - 23'd1, Q - 23'd1, 8'h33, 1'b0, 23'd0, 23'd8380415);
    tbl[3] = mk(23'd100, 23'd555, 23'd0, 8'h44, 1'b0, 23'd100, 23'd100);
    tbl[4] = mk(23'd8380407, 23'd10, 23'd1, 8'h55, 1'b0, 23'd0, 23'd8380397);
    tbl[5] = mk(23'd3, 23'd10, 23'd1, 8'h66, 1'b0, 23'd13, 23'd8380410);
    tbl[6] = mk(23'd0, 23'd4194304, 23'd2, 8'h77, 1'b0, 23'd8191, 23'd8372226);
    tbl[7] = mk(23'd5, Q - 23'd1, 23'd2, 8'h88, 1'b0, 23'd3, 23'd7);
    tbl[8] = mk(23'd1000, 23'd2, 23'd3, 8'hFF, 1'b0, 23'd1006, 23'd994);
    n_tbl = 9;
`ifdef NTT_BUTTERFLY_GS_EN
    tbl[9]  = mk(23'd5, 23'd3, 23'd2, 8'h99, 1'b1, 23'd8, 23'd4);
    tbl[10] = mk(23'd3, 23'd5, 23'd1, 8'hAA, 1'b1, 23'd8, 23'd8380415);
    tbl[11] = mk(Q - 23'd1, 23'd1, Q - 23'd1, 8'hBB, 1'b1, 23'd0, 23'd2);
    n_tbl = 12;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_a", 32'(out_a), 32'd0);
    check("reset.out_b", 32'(out_b), 32'd0);
    check("reset.out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < n_tbl; i++) send_one(tbl[i], $sformatf("vec%0d", i));

    // 16 back-to-back random CT beats with out_ready low in cycles 6-9.
    for (int i = 0; i < 16; i++)
      sv[i] = model(23'($urandom % 32'd8380417), 23'($urandom % 32'd8380417),
                    23'($urandom % 32'd8380417), 8'(8'h40 + i), 1'b0);
    sn = 16;
    run_stream(6, 9, "stream");

    // Reset flush: three beats accepted, then reset before any of them emerges.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_beat(mk(23'(k + 1), 23'd1, 23'd1, 8'(8'hE0 + k), 1'b0, 23'd0, 23'd0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.out_a", 32'(out_a), 32'd0);
    check("flush.out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    check("flush.in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush.no_ghost_beats", 32'(seen), 32'd0);
    send_one(mk(23'd7, 23'd0, 23'd9, 8'h5A, 1'b0, 23'd7, 23'd7), "post_reset");

`ifdef NTT_BUTTERFLY_GS_EN
    // Alternating CT/GS beats back to back.
    sv[0] = mk(23'd5, 23'd3, 23'd1, 8'hC0, 1'b0, 23'd8, 23'd2);
    sv[1] = mk(23'd5, 23'd3, 23'd2, 8'hC1, 1'b1, 23'd8, 23'd4);
    sv[2] = mk(Q - 23'd1, Q - 23'd1, Q - 23'd1, 8'hC2, 1'b0, 23'd0, 23'd8380415);
    sv[3] = mk(23'd3, 23'd5, 23'd1, 8'hC3, 1'b1, 23'd8, 23'd8380415);
    sv[4] = mk(23'd0, 23'd1, 23'h495e02, 8'hC4, 1'b0, 23'd4808194, 23'd3572223);
    sv[5] = mk(Q - 23'd1, 23'd1, Q - 23'd1, 8'hC5, 1'b1, 23'd0, 23'd2);
    sn = 6;
    run_stream(1000, -1, "mixed");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
